// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Computes a WIDTH-bit sum a + b + cin using one 4-bit ripple slice. It
//   processes one nibble per clock, least significant nibble first. A
//   registered carry links successive nibbles. A start/busy/done handshake
//   faces the requester.
//
//   Optional feature: define SIGNED_OVF_EN to add the ovf output. ovf is the
//   signed overflow of the completed addition.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   a, b   in   WIDTH-bit operands, captured on the accepted start
//   cin    in   carry into nibble 0, captured on the accepted start
//   busy   out  high while the addition runs and during the done cycle
//   done   out  one-cycle pulse, sum/cout (and ovf) valid
//   sum    out  WIDTH-bit result register
//   cout   out  carry out of the most significant nibble
//   ovf    out  signed overflow (SIGNED_OVF_EN only)

module nibble_serial_add_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q,   idx_d;
   logic [WIDTH-1:0]  a_q,     a_d;
   logic [WIDTH-1:0]  b_q,     b_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  sum_q,   sum_d;
   logic              cout_q,  cout_d;
`ifdef SIGNED_OVF_EN
   logic              ovf_q,   ovf_d;
`endif

   // Nibble slice datapath
   logic [IDXW+1:0]   base;
   logic [3:0]        a_nib;
   logic [3:0]        b_nib;
   logic [3:0]        s_nib;
   logic [4:0]        c;      // c[i] is the carry into bit i of the slice

   always_comb begin
      base  = {idx_q, 2'b00};
      a_nib = a_q[base +: 4];
      b_nib = b_q[base +: 4];
      s_nib = '0;
      c     = '0;
      c[0]  = carry_q;
      for (int unsigned i = 0; i < 4; i++) begin
         s_nib[i] = a_nib[i] ^ b_nib[i] ^ c[i];
         c[i+1]   = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
`ifdef SIGNED_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[base +: 4] = s_nib;
            carry_d          = c[4];
            if (idx_q == LAST_IDX) begin
               // Park the index at 0 so it never steps past the last nibble.
               idx_d   = '0;
               cout_d  = c[4];
`ifdef SIGNED_OVF_EN
               ovf_d   = c[3] ^ c[4];
`endif
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SIGNED_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed testbench for nibble_serial_add_ctrl (WIDTH=16).
// With SIGNED_OVF_EN defined, the testbench also covers the ovf output.

module tb_nibble_serial_add_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a     = '0;
   logic [15:0] b     = '0;
   logic        cin   = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
`ifdef SIGNED_OVF_EN
   logic        ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SIGNED_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Stimulus only. Call it at a sample point (1 time unit after a rising edge).
   // k counts the edges after the accept edge. The task returns the first k at
   // which done was seen, the number of samples with busy high, and the number
   // of done pulses over a 12-cycle window.
   task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          output int lat, output int busy_cnt, output int done_cnt);
      a = av; b = bv; cin = cv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (lat < 0) lat = k;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got %h want 0000", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SIGNED_OVF_EN
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat, bc, dc;
      run_add(16'h1234, 16'h4321, 1'b0, lat, bc, dc);
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", lat); end
      n_cmp++; if (bc != 5) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
      n_cmp++; if (dc != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", dc); end
      n_cmp++; if (sum !== 16'h5555) begin n_err++; $display("FAIL basic_sum got %h want 5555", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL basic_cout got %b want 0", cout); end
   endtask

   task automatic test_carry_chain();
      int lat, bc, dc;
      run_add(16'hFFFF, 16'h0001, 1'b0, lat, bc, dc);
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL carry1_sum got %h want 0000", sum); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL carry1_cout got %b want 1", cout); end
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL carry1_latency got %0d want 4", lat); end
      run_add(16'h0001, 16'h0002, 1'b0, lat, bc, dc);
      n_cmp++; if (sum !== 16'h0003) begin n_err++; $display("FAIL small_sum got %h want 0003", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL small_cout got %b want 0", cout); end
      run_add(16'hFFFF, 16'h0000, 1'b1, lat, bc, dc);
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL carry_cin_sum got %h want 0000", sum); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL carry_cin_cout got %b want 1", cout); end
      n_cmp++; if (dc != 1) begin n_err++; $display("FAIL carry_cin_done_pulses got %0d want 1", dc); end
   endtask

   task automatic test_ignore_start();
      int lat = -1;
      int dc  = 0;
      a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (k == 0) begin a = 16'hAAAA; b = 16'hFFFF; cin = 1'b1; start = 1'b1; end
         if (k == 1) start = 1'b0;
         if (done) begin
            dc++;
            if (lat < 0) lat = k;
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (dc != 1) begin n_err++; $display("FAIL ignore_done_pulses got %0d want 1", dc); end
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL ignore_latency got %0d want 4", lat); end
      n_cmp++; if (sum !== 16'h1010) begin n_err++; $display("FAIL ignore_sum got %h want 1010", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL ignore_cout got %b want 0", cout); end
   endtask

   task automatic test_async_reset();
      int lat, bc, dc;
      int seen_busy = 0;
      int seen_done = 0;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      // Two low nibbles written on top of the previous 0x1010 result
      n_cmp++; if (sum !== 16'h1033) begin n_err++; $display("FAIL partial_sum got %h want 1033", sum); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL async_done got %b want 0", done); end
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL async_sum got %h want 0000", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL async_cout got %b want 0", cout); end
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (busy) seen_busy++;
         if (done) seen_done++;
      end
      n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL post_reset_done got %0d want 0", seen_done); end
      n_cmp++; if (seen_busy != 0) begin n_err++; $display("FAIL post_reset_busy got %0d want 0", seen_busy); end
      run_add(16'h0001, 16'h0001, 1'b0, lat, bc, dc);
      n_cmp++; if (sum !== 16'h0002) begin n_err++; $display("FAIL post_reset_sum got %h want 0002", sum); end
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL post_reset_latency got %0d want 4", lat); end
   endtask

   task automatic test_back_to_back();
      int prev = -1;
      int dc   = 0;
      int bad_interval = 0;
      int bad_result   = 0;
      int unstable     = 0;
      a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      // Accepts land on edges 0, 6, 12 and 18. One idle cycle follows each
      // done cycle, so done pulses appear 6 edges apart at k = 4, 10, 16, 22.
      for (int k = 0; k < 30; k++) begin
         if (done) begin
            dc++;
            if (prev >= 0 && (k - prev) != 6) bad_interval++;
            if (sum !== 16'h0000 || cout !== 1'b1) bad_result++;
`ifdef SIGNED_OVF_EN
            if (ovf !== 1'b1) bad_result++;
`endif
            prev = k;
         end
         if (prev >= 0 && (sum !== 16'h0000 || cout !== 1'b1)) unstable++;
         if (k == 19) start = 1'b0;
         @(posedge clk); #1;
      end
      n_cmp++; if (dc != 4) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 4", dc); end
      n_cmp++; if (bad_interval != 0) begin n_err++; $display("FAIL b2b_interval bad=%0d want 0", bad_interval); end
      n_cmp++; if (bad_result != 0) begin n_err++; $display("FAIL b2b_result bad=%0d want 0", bad_result); end
      n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL b2b_sum_stable bad=%0d want 0", unstable); end
   endtask

`ifdef SIGNED_OVF_EN
   task automatic test_signed_ovf();
      int lat, bc, dc;
      int got_done = 0;
      run_add(16'h7FFF, 16'h0001, 1'b0, lat, bc, dc);
      n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pos_ovf got %b want 1", ovf); end
      n_cmp++; if (sum !== 16'h8000) begin n_err++; $display("FAIL ovf_pos_sum got %h want 8000", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL ovf_pos_cout got %b want 0", cout); end
      a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_accept got %b want 0", ovf); end
      for (int k = 0; k < 12 && got_done == 0; k++) begin
         @(posedge clk); #1;
         if (done) got_done = 1;
      end
      n_cmp++; if (got_done != 1) begin n_err++; $display("FAIL ovf_wrap_done_timeout got %0d want 1", got_done); end
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_wrap_ovf got %b want 0", ovf); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL ovf_wrap_cout got %b want 1", cout); end
      n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL ovf_wrap_sum got %h want 0000", sum); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      run_add(16'h8000, 16'h8000, 1'b0, lat, bc, dc);
      n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_neg_ovf got %b want 1", ovf); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL ovf_neg_cout got %b want 1", cout); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_carry_chain();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();
`ifdef SIGNED_OVF_EN
      test_signed_ovf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
